// File: rtl/result_display.sv
// -----------------------------------------------------------------------------
// result_display
//   Shows the processor's 14-bit result register on a 5-digit, time-multiplexed,
//   active-low 7-segment display. A sequential double-dabble engine (one shift
//   per clock, W shifts) converts each new value to BCD. The converted digits
//   are latched into a display register only after the conversion completes,
//   so the scanned digits never show partial BCD. Leading zeros are blanked.
//
//   Optional feature (macro RESULT_DISPLAY_HEX_EN): adds the hex_sel input.
//   When hex_sel is high the lower four digits show the last captured value
//   in hexadecimal and the top digit is blanked.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   resultado  unsigned value to display, sampled every cycle (no strobe)
//   hex_sel    (RESULT_DISPLAY_HEX_EN only) 1 = hex view, 0 = decimal view
//   busy       high while a conversion is in progress
//   seg        active-low segments {g,f,e,d,c,b,a}
//   an         active-low one-hot digit enables, an[0] = units digit
//   dp         decimal point, active-low, held off
//
// Parameters
//   W            width of resultado; the digit layout assumes 14 (max 16383)
//   REFRESH_DIV  clk cycles each digit stays lit; minimum 2
// -----------------------------------------------------------------------------
module result_display #(
    parameter int W           = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] resultado,
`ifdef RESULT_DISPLAY_HEX_EN
    input  logic         hex_sel,
`endif
    output logic         busy,
    output logic [6:0]   seg,
    output logic [4:0]   an,
    output logic         dp
);

    localparam int ND = 5;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int PW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                 state;
    logic [W-1:0]           last_val;
    logic [W-1:0]           bin;
    logic [4*ND-1:0]        bcd;
    logic [4*ND-1:0]        bcd_adj;
    logic [CW-1:0]          cnt;
    logic [ND-1:0][3:0]     disp;

    logic [PW-1:0]          presc;
    logic [2:0]             idx;

    // ------------------------------------------------------------------
    // Double-dabble: every nibble >= 5 gets +3 before the shift so that
    // the left shift carries correctly into the next decimal digit.
    // ------------------------------------------------------------------
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < ND; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM. last_val only follows resultado at capture time, so
    // values that come and go while busy are skipped and the latest value
    // is picked up on the first IDLE cycle after the conversion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_val <= '0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp     <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (resultado != last_val) begin
                        bin      <= resultado;
                        last_val <= resultado;
                        bcd      <= '0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= {bcd_adj[4*ND-2:0], bin[W-1]};
                    bin <= {bin[W-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W-1))
                        state <= LOAD;
                end
                LOAD: begin
                    disp  <= bcd;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan prescaler and digit index, free-running regardless of the FSM.
    // ------------------------------------------------------------------
`ifdef RESULT_DISPLAY_HEX_EN
    logic hex_mode;   // hex_sel sampled at slot boundaries only
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
`ifdef RESULT_DISPLAY_HEX_EN
            hex_mode <= 1'b0;
`endif
        end else if (presc == PW'(REFRESH_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
`ifdef RESULT_DISPLAY_HEX_EN
            hex_mode <= hex_sel;
`endif
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Segment decode (active low, {g,f,e,d,c,b,a}).
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0:    seg_decode = 7'b1000000;
            4'h1:    seg_decode = 7'b1111001;
            4'h2:    seg_decode = 7'b0100100;
            4'h3:    seg_decode = 7'b0110000;
            4'h4:    seg_decode = 7'b0011001;
            4'h5:    seg_decode = 7'b0010010;
            4'h6:    seg_decode = 7'b0000010;
            4'h7:    seg_decode = 7'b1111000;
            4'h8:    seg_decode = 7'b0000000;
            4'h9:    seg_decode = 7'b0010000;
`ifdef RESULT_DISPLAY_HEX_EN
            4'hA:    seg_decode = 7'b0001000;
            4'hB:    seg_decode = 7'b0000011;
            4'hC:    seg_decode = 7'b1000110;
            4'hD:    seg_decode = 7'b0100001;
            4'hE:    seg_decode = 7'b0000110;
            4'hF:    seg_decode = 7'b0001110;
`endif
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [ND-1:0][3:0] shown;
    logic [ND-1:0]      blank;

    // Outputs depend only on registered disp/last_val and idx, never on the
    // in-flight BCD registers.
    always_comb begin
`ifdef RESULT_DISPLAY_HEX_EN
        if (hex_mode)
            shown = {4'h0, 2'b00, last_val[13:12], last_val[11:8],
                     last_val[7:4], last_val[3:0]};
        else
            shown = disp;
`else
        shown = disp;
`endif
        // A digit is blank when it and every digit above it are zero; the
        // units digit always shows. In hex view shown[4] is 0, so it blanks.
        blank        = '0;
        blank[ND-1]  = (shown[ND-1] == 4'h0);
        for (int k = ND - 2; k >= 1; k--)
            blank[k] = blank[k+1] && (shown[k] == 4'h0);
        blank[0]     = 1'b0;

        seg = blank[idx] ? 7'b1111111 : seg_decode(shown[idx]);
        an  = ~(5'b00001 << idx);
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_result_display.sv
module tb_result_display;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] resultado = '0;
`ifdef RESULT_DISPLAY_HEX_EN
    logic        hex_sel = 1'b0;
`endif
    logic        busy;
    logic [6:0]  seg;
    logic [4:0]  an;
    logic        dp;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    result_display #(.W(14), .REFRESH_DIV(RD)) dut (
        .clk       (clk),
        .rst       (rst),
        .resultado (resultado),
`ifdef RESULT_DISPLAY_HEX_EN
        .hex_sel   (hex_sel),
`endif
        .busy      (busy),
        .seg       (seg),
        .an        (an),
        .dp        (dp)
    );

    function automatic logic [6:0] seg_code(input int d);
        case (d)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b0001000;
            11: return 7'b0000011;
            12: return 7'b1000110;
            13: return 7'b0100001;
            14: return 7'b0000110;
            15: return 7'b0001110;
            default: return 7'b1111111;
        endcase
    endfunction

    // Expected segments for digit k of value v (decimal or hex view).
    function automatic logic [6:0] exp_seg(input int v, input int k, input bit hx);
        int base = hx ? 16 : 10;
        int p = 1;
        for (int j = 0; j < k; j++) p = p * base;
        if (hx && k == 4) return 7'b1111111;
        if (k > 0 && v < p) return 7'b1111111;
        return seg_code((v / p) % base);
    endfunction

    // Bounded wait for one complete conversion (busy rises, then falls).
    task automatic wait_conv(input string name);
        int to = 0;
        while (busy !== 1'b1 && to < 40) begin @(negedge clk); to++; end
        while (busy === 1'b1 && to < 80) begin @(negedge clk); to++; end
        checks++;
        if (to >= 80 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_conv_timeout busy=%b after %0d cycles, want 0", name, busy, to);
        end
    endtask

    function automatic int pop_exp();
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty got size 0 want >0");
            return 0;
        end
        return exp_q.pop_front();
    endfunction

    // Align to the start of digit 0's slot, then check a full 5-slot scan.
    task automatic scan_check(input string name, input int v, input bit hx);
        int to = 0;
        logic [4:0] ea;
        logic [6:0] es;
        while (an !== 5'b01111 && to < 40) begin @(negedge clk); to++; end
        while (an === 5'b01111 && to < 40) begin @(negedge clk); to++; end
        checks++;
        if (to >= 40) begin
            errors++;
            $display("FAIL %s_scan_sync an=%b never cycled", name, an);
            return;
        end
        for (int i = 0; i < 5 * RD; i++) begin
            if (i > 0) @(negedge clk);
            ea = ~(5'b00001 << (i / RD));
            es = exp_seg(v, i / RD, hx);
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("FAIL %s_scan[%0d] an=%b seg=%b want an=%b seg=%b", name, i, an, seg, ea, es);
            end
        end
    endtask

    // Check whichever digit is currently lit against value v.
    task automatic check_now(input string name, input int v);
        int k = -1;
        for (int j = 0; j < 5; j++) if (an[j] === 1'b0) k = j;
        checks++;
        if ($countones(~an) != 1 || k < 0) begin
            errors++;
            $display("FAIL %s_onehot an=%b want one low bit", name, an);
        end else if (seg !== exp_seg(v, k, 1'b0)) begin
            errors++;
            $display("FAIL %s_digit%0d seg=%b want %b", name, k, seg, exp_seg(v, k, 1'b0));
        end
    endtask

    task automatic drive(input int v);
        @(posedge clk); #1;
        resultado = 14'(v);
        exp_q.push_back(v);
    endtask

    task automatic test_reset();
        int hi = 0;
        rst = 1'b1;
        resultado = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || an !== 5'b11110 || seg !== 7'b1000000 || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs busy=%b an=%b seg=%b dp=%b want 0 11110 1000000 1", busy, an, seg, dp);
        end
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy === 1'b1) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL reset_idle_busy high for %0d cycles want 0", hi);
        end
    endtask

    task automatic test_busy_len();
        int n = 0;
        int to = 0;
        drive(12345);
        @(negedge clk);
        while (busy !== 1'b1 && to < 10) begin @(negedge clk); to++; end
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
        checks++;
        if (n != 15) begin
            errors++;
            $display("FAIL busy_len got %0d cycles want 15", n);
        end
        scan_check("v12345", pop_exp(), 1'b0);
    endtask

    task automatic test_values();
        int vals[3] = '{16383, 7, 0};
        foreach (vals[i]) begin
            drive(vals[i]);
            wait_conv("values");
            scan_check("values", pop_exp(), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        int to = 0;
        drive(100);
        while (busy !== 1'b1 && to < 10) begin @(negedge clk); to++; end
        repeat (4) @(posedge clk);
        #1 resultado = 14'd200;
        exp_q.push_back(200);
        to = 0;
        while (busy === 1'b1 && to < 40) begin @(negedge clk); to++; end
        begin
            int v1 = pop_exp();
            check_now("b2b_first", v1);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b_restart busy=%b want 1", busy);
            end
            for (int i = 0; i < 12; i++) begin
                check_now("b2b_hold", v1);
                @(negedge clk);
            end
        end
        wait_conv("b2b");
        scan_check("b2b_second", pop_exp(), 1'b0);
    endtask

    task automatic test_reset_mid();
        int to = 0;
        drive(999);
        while (busy !== 1'b1 && to < 10) begin @(negedge clk); to++; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || an !== 5'b11110 || seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_mid busy=%b an=%b seg=%b want 0 11110 1000000", busy, an, seg);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_conv("reset_mid");
        scan_check("reset_mid", pop_exp(), 1'b0);
    endtask

`ifdef RESULT_DISPLAY_HEX_EN
    task automatic test_hex();
        int v;
        hex_sel = 1'b1;
        drive(14'h2A5F);
        wait_conv("hex");
        v = pop_exp();
        scan_check("hex_on", v, 1'b1);
        hex_sel = 1'b0;
        scan_check("hex_off", v, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_busy_len();
        test_values();
        test_back_to_back();
        test_reset_mid();
`ifdef RESULT_DISPLAY_HEX_EN
        test_hex();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_display.md
Name: result_display

Overview:
Downstream consumer of the 14-bit `resultado` value held by the processor's output register (RIO).
- Converts the value to decimal BCD with a sequential double-dabble engine (14 shift cycles).
- Drives a 5-digit, time-multiplexed, active-low 7-segment display.
- Blanks leading zeros.
- Sits between the core's `resultado` bus and the board display pins.

Parameters:
- W, 14, width of `resultado`; the BCD engine is sized for 5 digits (max 16383).
- REFRESH_DIV, 50000, clk cycles each digit stays lit before the scan advances; minimum value 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- resultado  input  14  unsigned value to display; no strobe, sampled every cycle.
- busy  output  1  high while a conversion is in progress.
- seg  output  7  active-low segments {g,f,e,d,c,b,a}.
- an  output  5  active-low digit enables, one-hot; an[0] is the units digit.
- dp  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, last_val=0, shift/BCD regs=0, disp (5x4-bit)=0.
  - prescaler=0, digit index=0.
  - Outputs: busy=0, an=5'b11110, seg=7'b1000000 ('0'), dp=1.
- FSM IDLE:
  - If resultado != last_val: capture resultado into the binary shift reg, last_val<=resultado, bcd<=0, cnt<=0, go SHIFT.
  - Otherwise stay in IDLE.
- FSM SHIFT:
  - Each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1; cnt++.
  - After the 14th shift, go LOAD.
- FSM LOAD: disp<=bcd, go IDLE.
- busy=1 in SHIFT and LOAD, 0 in IDLE.
- Latency: capture is edge 1, shifts are edges 2-15, disp is written on edge 16. The new digits are visible on the next scan slot of each digit.
- resultado changes during SHIFT/LOAD are ignored by the engine. On return to IDLE the compare against last_val detects the newest value and starts a new conversion. Intermediate values may never be shown; the final stable value always is.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 continuously, independent of the FSM.
  - At terminal count: prescaler<=0, index<=index+1, wrapping 4->0.
  - an=~(1<<index).
- Segment decode of disp[index]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Codes A-F are used only by the hex option: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Leading-zero blanking: digit k>0 shows seg=1111111 when it and all higher digits are 0. Digit 0 is never blanked.
- Display updates are glitch-free: seg/an are derived only from disp and index, never from in-flight BCD.
- Reset mid-conversion aborts immediately. The display returns to "0". After release, a nonzero resultado triggers a fresh conversion.

Optional Feature:
- Macro: RESULT_DISPLAY_HEX_EN.
- When defined:
  - Adds input port `hex_sel` (1 bit), placed after `resultado`.
  - hex_sel=1: digits 0-3 show last_val[3:0], [7:4], [11:8], {2'b00,last_val[13:12]} in hex. Digit 4 is always blanked. Leading-zero blanking still applies. busy and the BCD engine continue to run unaffected.
  - hex_sel=0: decimal behaviour as above.
  - hex_sel changes take effect on the next scan slot.
- When undefined: no hex_sel port, decimal only, no A-F decode logic.

Test Plan:
- Reset: assert rst 3 cycles mid-run, release -> busy=0, an=11110, seg=1000000, dp=1; with resultado=0, busy stays 0.
- REFRESH_DIV=4, resultado=12345 -> busy=1 for exactly 15 cycles starting the cycle after capture. Scan then shows an 11110/11101/11011/10111/01111 with seg 0010010, 0011001, 0110000, 0100100, 1111001; each digit held 4 cycles.
- resultado=16383 (max) -> digits 3,8,3,6,1 (units first). resultado=7 -> digit0 seg=1111000, digits 1-4 seg=1111111.
- resultado=100, then 200 on the 5th SHIFT cycle -> disp shows 100 after conversion 1. A second conversion starts in the following IDLE cycle; disp=200 sixteen edges later.
- Assert rst during SHIFT of value 999 -> display "0", busy=0. After release, conversion of 999 completes normally.
- With RESULT_DISPLAY_HEX_EN, resultado=14'h2A5F, hex_sel=1 -> digits 0-3 = F,5,A,2 (0001110, 0010010, 0001000, 0100100), digit4 blank. hex_sel=0 -> decimal 10847.
